// File: rtl/int_ctrl.sv
// Purpose: synchronise, debounce, mode-select, latch and mask five external interrupt lines plus the CP0 timer into a 6-bit vector.
// Latency: level line reaches int_o SYNC_STAGES+FILTER_LEN+2 edges after the input is first sampled; timer reaches int_o in 2 edges.
// Backpressure: none; the register port accepts a write every cycle and int_o/irq_o are plain levels.
module int_ctrl #(
   parameter int SYNC_STAGES = 2,   // legal range 2..3
   parameter int FILTER_LEN  = 4    // legal range 1..15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ext_int_i,
   input  logic        timer_int_i,
   input  logic        we_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic [5:0]  int_o,
   output logic        irq_o
);

   // Counter value at which a still-mismatched sample flips the filtered level.
   localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

   localparam logic [1:0] ADDR_MODE = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd1;
   localparam logic [1:0] ADDR_PEND = 2'd2;
   localparam logic [1:0] ADDR_RAW  = 2'd3;

   // Synchroniser chain: stage 0 takes the raw pins, the last stage is the usable sample.
   logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
   logic [4:0]                  sync;

   // Debounce state per line.
   logic [4:0][3:0] cnt_q, cnt_d;
   logic [4:0]      flt_q, flt_d;
   logic [4:0]      flt_prev_q, flt_prev_d;

   // Software-visible registers.
   logic [4:0] mode_q, mode_d;
   logic [5:0] mask_q, mask_d;
   logic [5:0] pend_q, pend_d;

   // Registered outputs.
   logic [5:0] int_q, int_d;
   logic       irq_q, irq_d;

   // Decoded write strobes and derived masks.
   logic       wr_mode, wr_mask, wr_pend;
   logic [4:0] mode_chg;
   logic [4:0] w1c;
   logic [4:0] flt_rise;

   // Upper write-data bits have no register behind them.
   logic unused_data;
   assign unused_data = ^data_i[31:6];

   assign sync = sync_q[SYNC_STAGES-1];

   // Shift each external line one stage further into the clock domain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], ext_int_i};
   end

   // Debounce: the filtered level only follows sync after FILTER_LEN consecutive disagreeing samples.
   always_comb begin
      cnt_d      = '0;
      flt_d      = flt_q;
      flt_prev_d = flt_q;
      for (int i = 0; i < 5; i++) begin
         if (sync[i] != flt_q[i]) begin
            if (cnt_q[i] == FLT_LAST) begin
               flt_d[i] = sync[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 4'd1;
            end
         end
      end
   end

   // Register writes and pending-state update.
   always_comb begin
      wr_mode  = we_i && (addr_i == ADDR_MODE);
      wr_mask  = we_i && (addr_i == ADDR_MASK);
      wr_pend  = we_i && (addr_i == ADDR_PEND);

      mode_d   = wr_mode ? data_i[4:0] : mode_q;
      mask_d   = wr_mask ? data_i[5:0] : mask_q;

      // A line whose mode flips starts from a clean pending bit.
      mode_chg = wr_mode ? (data_i[4:0] ^ mode_q) : 5'd0;
      // Clearing only affects lines currently in edge mode.
      w1c      = wr_pend ? (data_i[4:0] & mode_q) : 5'd0;
      flt_rise = flt_q & ~flt_prev_q;

      pend_d   = pend_q;
      for (int i = 0; i < 5; i++) begin
         if (mode_chg[i]) begin
            pend_d[i] = 1'b0;
         end else if (mode_q[i]) begin
            // A new rising edge wins over a simultaneous clear.
            pend_d[i] = flt_rise[i] | (pend_q[i] & ~w1c[i]);
         end else begin
            pend_d[i] = flt_q[i];
         end
      end
      pend_d[5] = timer_int_i;
   end

   // Masked vector and its OR, both one edge behind PENDING/MASK.
   always_comb begin
      int_d = pend_q & mask_q;
      irq_d = |(pend_q & mask_q);
   end

   // Read mux; RAW shows the debounced levels and the live timer input.
   always_comb begin
      data_o = '0;
      case (addr_i)
         ADDR_MODE: data_o = {27'd0, mode_q};
         ADDR_MASK: data_o = {26'd0, mask_q};
         ADDR_PEND: data_o = {26'd0, pend_q};
         ADDR_RAW:  data_o = {26'd0, timer_int_i, flt_q};
         default:   data_o = '0;
      endcase
   end

   // All state flops; reset discards every in-flight sample and pending bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q     <= '0;
         cnt_q      <= '0;
         flt_q      <= '0;
         flt_prev_q <= '0;
         mode_q     <= '0;
         mask_q     <= '0;
         pend_q     <= '0;
         int_q      <= '0;
         irq_q      <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         cnt_q      <= cnt_d;
         flt_q      <= flt_d;
         flt_prev_q <= flt_prev_d;
         mode_q     <= mode_d;
         mask_q     <= mask_d;
         pend_q     <= pend_d;
         int_q      <= int_d;
         irq_q      <= irq_d;
      end
   end

   assign int_o = int_q;
   assign irq_o = irq_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Purpose: random and directed stimulus for int_ctrl, scored against a behavioural model.
// Latency: expectations are pushed 2 time units after each edge and popped at the following falling edge.
// Backpressure: none; the monitor consumes one expectation per cycle.
module tb_int_ctrl;

   localparam int SYNC_STAGES = 2;
   localparam int FILTER_LEN  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  ext_int_i = '0;
   logic        timer_int_i = 1'b0;
   logic        we_i = 1'b0;
   logic [1:0]  addr_i = '0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic [5:0]  int_o;
   logic        irq_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0]  int_v;
      logic        irq;
      logic [31:0] dat;
   } exp_t;

   exp_t sb[$];

   int_ctrl #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) dut (
      .clk         (clk),
      .rst         (rst),
      .ext_int_i   (ext_int_i),
      .timer_int_i (timer_int_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .data_o      (data_o),
      .int_o       (int_o),
      .irq_o       (irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [4:0] m_sync_hist[$];  // last SYNC_STAGES pin samples, oldest first
   logic [4:0] m_win[$];        // last FILTER_LEN synced samples seen by the filter
   logic [4:0] m_flt, m_flt_prev, m_mode;
   logic [5:0] m_mask, m_pend, m_int;
   logic       m_irq;

   function automatic void model_reset();
      m_sync_hist = {};
      m_win       = {};
      for (int k = 0; k < SYNC_STAGES; k++) m_sync_hist.push_back(5'd0);
      for (int k = 0; k < FILTER_LEN; k++)  m_win.push_back(5'd0);
      m_flt = '0; m_flt_prev = '0; m_mode = '0;
      m_mask = '0; m_pend = '0; m_int = '0; m_irq = 1'b0;
   endfunction

   function automatic void model_edge(input logic [4:0] ext, input logic tmr, input logic we,
                                      input logic [1:0] addr, input logic [31:0] dat);
      logic [4:0] sync_now, flt_new, rise, chg, clr;
      logic [5:0] pend_new;
      bit         all_diff;
      sync_now = m_sync_hist[0];
      m_sync_hist.push_back(ext);
      void'(m_sync_hist.pop_front());

      // A line flips once its last FILTER_LEN synced samples all disagree with it.
      m_win.push_back(sync_now);
      void'(m_win.pop_front());
      flt_new = m_flt;
      for (int i = 0; i < 5; i++) begin
         all_diff = 1'b1;
         foreach (m_win[k]) if (m_win[k][i] == m_flt[i]) all_diff = 1'b0;
         if (all_diff) flt_new[i] = ~m_flt[i];
      end

      rise = m_flt & ~m_flt_prev;
      chg  = (we && addr == 2'd0) ? (dat[4:0] ^ m_mode) : 5'd0;
      clr  = (we && addr == 2'd2) ? dat[4:0] : 5'd0;
      for (int i = 0; i < 5; i++) begin
         if (chg[i])          pend_new[i] = 1'b0;
         else if (!m_mode[i]) pend_new[i] = m_flt[i];
         else if (rise[i])    pend_new[i] = 1'b1;
         else if (clr[i])     pend_new[i] = 1'b0;
         else                 pend_new[i] = m_pend[i];
      end
      pend_new[5] = tmr;

      m_int      = m_pend & m_mask;
      m_irq      = (m_int != 6'd0);
      m_flt_prev = m_flt;
      m_flt      = flt_new;
      m_pend     = pend_new;
      if (we && addr == 2'd0) m_mode = dat[4:0];
      if (we && addr == 2'd1) m_mask = dat[5:0];
   endfunction

   function automatic logic [31:0] model_read(input logic [1:0] addr, input logic tmr);
      case (addr)
         2'd0:    return {27'd0, m_mode};
         2'd1:    return {26'd0, m_mask};
         2'd2:    return {26'd0, m_pend};
         default: return {26'd0, tmr, m_flt};
      endcase
   endfunction

   // ---------------- stimulus ----------------
   // One cycle: let the DUT take the held inputs, advance the model, drive the next inputs,
   // optionally pulse reset mid-cycle, then queue the expected outputs.
   task automatic step(input logic [4:0] ext, input logic tmr, input logic we,
                       input logic [1:0] addr, input logic [31:0] dat, input bit do_rst);
      exp_t e;
      @(posedge clk);
      model_edge(ext_int_i, timer_int_i, we_i, addr_i, data_i);
      #2;
      ext_int_i = ext; timer_int_i = tmr; we_i = we; addr_i = addr; data_i = dat;
      if (do_rst) begin
         #1 rst = 1'b0;
         #1;
         chk("rst_async_int", {26'd0, int_o}, 32'd0);
         chk("rst_async_irq", {31'd0, irq_o}, 32'd0);
         model_reset();
      end
      e.int_v = m_int;
      e.irq   = m_irq;
      e.dat   = model_read(addr, tmr);
      sb.push_back(e);
      if (do_rst) #3 rst = 1'b1;
   endtask

   task automatic idle(input int n, input logic [1:0] addr);
      for (int k = 0; k < n; k++) step(ext_int_i, timer_int_i, 1'b0, addr, 32'd0, 1'b0);
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] dat);
      step(ext_int_i, timer_int_i, 1'b1, addr, dat, 1'b0);
   endtask

   // ---------------- monitor ----------------
   // Pops one expectation per falling edge and compares it against the DUT outputs.
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_int_o", {26'd0, int_o}, {26'd0, e.int_v});
            chk("sb_irq_o", {31'd0, irq_o}, {31'd0, e.irq});
            chk("sb_data_o", data_o, e.dat);
         end
      end
   end

   initial begin
      logic seen;
      model_reset();

      // Reset acts without a clock edge.
      #1 rst = 1'b0;
      #1;
      chk("reset_int_o", {26'd0, int_o}, 32'd0);
      chk("reset_irq_o", {31'd0, irq_o}, 32'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;

      for (int a = 0; a < 4; a++) begin
         step(5'd0, 1'b0, 1'b0, 2'(a), 32'd0, 1'b0);
         chk("reset_read", data_o, 32'd0);
      end

      // Level line 0: asserts on edge 8, deasserts 8 edges after release.
      wr(2'd1, 32'h01);
      wr(2'd0, 32'h00);
      idle(2, 2'd3);
      step(5'h01, 1'b0, 1'b0, 2'd3, 32'd0, 1'b0);
      for (int n = 1; n <= 8; n++) begin
         step(5'h01, 1'b0, 1'b0, 2'd3, 32'd0, 1'b0);
         if (n == 7) chk("lvl_rise_edge7", {26'd0, int_o}, 32'h00);
         if (n == 8) begin
            chk("lvl_rise_edge8", {26'd0, int_o}, 32'h01);
            chk("lvl_rise_irq", {31'd0, irq_o}, 32'd1);
         end
      end
      step(5'h00, 1'b0, 1'b0, 2'd3, 32'd0, 1'b0);
      for (int n = 1; n <= 8; n++) begin
         step(5'h00, 1'b0, 1'b0, 2'd3, 32'd0, 1'b0);
         if (n == 7) chk("lvl_fall_edge7", {26'd0, int_o}, 32'h01);
         if (n == 8) chk("lvl_fall_edge8", {26'd0, int_o}, 32'h00);
      end

      // Glitch filter on line 1: 3 cycles rejected, 5 cycles accepted.
      wr(2'd1, 32'h02);
      repeat (3) step(5'h02, 1'b0, 1'b0, 2'd3, 32'd0, 1'b0);
      seen = 1'b0;
      for (int n = 0; n < 12; n++) begin
         step(5'h00, 1'b0, 1'b0, 2'd3, 32'd0, 1'b0);
         seen = seen | data_o[1] | int_o[1];
      end
      chk("glitch3_rejected", {31'd0, seen}, 32'd0);
      repeat (5) step(5'h02, 1'b0, 1'b0, 2'd3, 32'd0, 1'b0);
      seen = 1'b0;
      for (int n = 0; n < 12; n++) begin
         step(5'h00, 1'b0, 1'b0, 2'd3, 32'd0, 1'b0);
         seen = seen | data_o[1];
      end
      chk("pulse5_raw", {31'd0, seen}, 32'd1);

      // Edge line 2: pending held after the pulse, W1C, and W1C racing a new edge.
      wr(2'd0, 32'h04);
      wr(2'd1, 32'h04);
      repeat (10) step(5'h04, 1'b0, 1'b0, 2'd2, 32'd0, 1'b0);
      idle(1, 2'd2);
      step(5'h00, 1'b0, 1'b0, 2'd2, 32'd0, 1'b0);
      idle(12, 2'd2);
      chk("edge_pending_held", data_o, 32'h04);
      chk("edge_int_held", {26'd0, int_o}, 32'h04);
      wr(2'd2, 32'h04);
      idle(1, 2'd2);
      chk("w1c_pending", data_o, 32'h00);
      idle(1, 2'd2);
      chk("w1c_int_o", {26'd0, int_o}, 32'h00);
      step(5'h04, 1'b0, 1'b0, 2'd2, 32'd0, 1'b0);
      for (int n = 1; n <= 5; n++) step(5'h04, 1'b0, 1'b0, 2'd2, 32'd0, 1'b0);
      step(5'h04, 1'b0, 1'b1, 2'd2, 32'h04, 1'b0);
      step(5'h04, 1'b0, 1'b0, 2'd2, 32'd0, 1'b0);
      chk("w1c_race_pending", data_o, 32'h04);
      step(5'h04, 1'b0, 1'b0, 2'd2, 32'd0, 1'b0);
      chk("w1c_race_int_o", {26'd0, int_o}, 32'h04);
      step(5'h00, 1'b0, 1'b0, 2'd2, 32'd0, 1'b0);
      idle(10, 2'd2);
      wr(2'd2, 32'h04);
      idle(2, 2'd2);

      // Timer: 2-edge latency, mask removal one edge after the write.
      wr(2'd1, 32'h20);
      step(5'h00, 1'b1, 1'b0, 2'd2, 32'd0, 1'b0);
      step(5'h00, 1'b1, 1'b0, 2'd2, 32'd0, 1'b0);
      chk("timer_edge1", {26'd0, int_o}, 32'h00);
      step(5'h00, 1'b1, 1'b0, 2'd2, 32'd0, 1'b0);
      chk("timer_edge2", {26'd0, int_o}, 32'h20);
      chk("timer_irq", {31'd0, irq_o}, 32'd1);
      wr(2'd1, 32'h00);
      idle(1, 2'd2);
      idle(1, 2'd2);
      chk("mask_off_int_o", {26'd0, int_o}, 32'h00);
      chk("mask_off_pending", data_o, 32'h20);

      // Reset while the timer interrupt is being driven out.
      wr(2'd1, 32'h20);
      idle(2, 2'd1);
      chk("pre_reset_int_o", {26'd0, int_o}, 32'h20);
      step(5'h00, 1'b1, 1'b0, 2'd1, 32'd0, 1'b1);
      step(5'h00, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0);
      chk("post_reset_mask", data_o, 32'h00);

      // Mode change on a pending edge line clears it on the write edge.
      wr(2'd0, 32'h08);
      wr(2'd1, 32'h08);
      repeat (10) step(5'h08, 1'b0, 1'b0, 2'd2, 32'd0, 1'b0);
      step(5'h00, 1'b0, 1'b0, 2'd2, 32'd0, 1'b0);
      idle(12, 2'd2);
      chk("mode_pending_before", data_o, 32'h08);
      wr(2'd0, 32'h00);
      idle(1, 2'd2);
      chk("mode_chg_pending", data_o, 32'h00);
      idle(1, 2'd2);
      chk("mode_chg_int_o", {26'd0, int_o}, 32'h00);

      // Randomised traffic scored by the model.
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] ext;
         logic       tmr;
         ext = ext_int_i;
         for (int i = 0; i < 5; i++) if ($urandom_range(0, 5) == 0) ext[i] = ~ext[i];
         tmr = ($urandom_range(0, 9) == 0) ? ~timer_int_i : timer_int_i;
         step(ext, tmr, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), $urandom,
              ($urandom_range(0, 799) == 0));
      end

      @(negedge clk);
      #1;
      chk("sb_drain", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Interrupt controller that sits directly upstream of the CP0 register block and drives its 6-bit hardware-interrupt input (the Cause[15:10] source).
- Synchronises and debounces five asynchronous external interrupt lines.
- Applies a per-line edge/level mode and latches pending state.
- Masks the result and presents a registered 6-bit vector; bit 5 carries CP0's own timer interrupt.
- Software access is through a small word-addressed register port on the memory bus.

Parameters:
SYNC_STAGES, 2, synchroniser flops per external line (legal range 2..3)
FILTER_LEN, 4, consecutive stable synced cycles before the filtered level changes (legal range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ext_int_i  in  5  asynchronous external interrupt requests, active-high
timer_int_i  in  1  timer interrupt from CP0, synchronous to clk, level
we_i  in  1  register write strobe
addr_i  in  2  register select
data_i  in  32  write data
data_o  out  32  read data (combinational from addr_i)
int_o  out  6  masked interrupt vector to CP0 int_i; bit 5 = timer
irq_o  out  1  OR-reduction of int_o, registered

Behaviour:
- Reset: rst low clears all flops asynchronously, regardless of clk:
  - synchroniser flops, filter counters, filtered levels, previous-filtered levels
  - MODE, MASK, PENDING
  - int_o = 0, irq_o = 0
  - After reset, data_o reads 0 for every address.
  - Reset asserted mid-operation discards all pending and in-flight state. Nothing is retained after release.
- Register map (addr_i); unused bits read 0 and ignore writes:
  - 0 MODE[4:0]: 1 = rising-edge line, 0 = level line. Read/write.
  - 1 MASK[5:0]: 1 = enabled. Read/write.
  - 2 PENDING[5:0]: read. Writing 1 to bits [4:0] clears edge-mode pending bits (W1C). Writes are ignored for level-mode bits and bit 5.
  - 3 RAW: bits[4:0] = filtered levels, bit 5 = timer_int_i. Read-only.
- Synchroniser: SYNC_STAGES-flop chain per line. Its output is sync[i].
- Filter, per line:
  - 4-bit counter cnt[i] and filtered level flt[i].
  - If sync[i] == flt[i]: cnt clears.
  - Otherwise cnt increments. When cnt reaches FILTER_LEN-1 while still mismatched, flt[i] takes sync[i] on that edge and cnt clears.
  - A glitch shorter than FILTER_LEN cycles never reaches flt.
- Pending update, every clk edge:
  - Level line: PENDING[i] <= flt[i].
  - Edge line: set when flt[i] & ~flt_d[i] (flt_d = flt delayed one cycle). Cleared by W1C. A simultaneous set and clear leaves the bit set.
  - Bit 5: PENDING[5] <= timer_int_i every cycle.
- MODE write: every bit whose mode changes has its PENDING cleared on that edge. Level bits then refill from flt on the next edge.
- MASK write: takes effect on int_o one edge later. PENDING is unaffected, so unmasking an already pending bit raises int_o on the following edge.
- Outputs:
  - int_o <= PENDING & MASK (registered).
  - irq_o <= |(PENDING & MASK), registered in parallel with int_o.
- Latency, defaults, from the first edge sampling ext_int_i high, steady:
  - level line: int_o bit high on edge SYNC_STAGES+FILTER_LEN+2 = 8
  - timer: int_o[5] high 2 edges after timer_int_i is sampled high
- Deassertion uses the same latency. An edge-mode bit stays high until cleared by W1C.

Test Plan:
- Reset, then read all 4 addresses -> data_o = 0 for each. Assert rst low mid-pulse -> int_o = 0 immediately, without waiting for a clk edge.
- MASK=0x01, MODE=0, hold ext_int_i[0]=1 -> int_o = 6'h01 and irq_o = 1 on the 8th edge. Drop the input -> int_o = 0 eight edges later.
- MASK=0x02, 3-cycle pulse on ext_int_i[1] -> RAW[1] and int_o stay 0. A 5-cycle pulse -> RAW[1] rises.
- MODE=0x04, MASK=0x04, 10-cycle pulse on ext_int_i[2] -> PENDING=0x04 and int_o[2] held after the pulse ends. Write 0x04 to addr 2 -> int_o[2]=0 two edges later. W1C issued in the same cycle as a new rising edge -> PENDING[2] stays 1.
- MASK=0x20, timer_int_i=1 -> int_o = 6'h20 two edges later. Write MASK=0 -> int_o = 0 one edge after the write, while PENDING[5] stays 1.
- Edge line pending, MASK=0x08, MODE=0x08 pending bit set, write MODE=0 with input low -> PENDING[3] cleared on the write edge and int_o[3] = 0 next edge.
